// File: rtl/aes_uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: frame layout, command and
// status bytes, FSM state encoding and frame pack/unpack helpers.
package aes_uart_pkg;

   localparam int unsigned FRAME_BYTES = 18;
   localparam int unsigned FRAME_W     = FRAME_BYTES * 8;

   typedef logic [7:0]   byte_t;
   typedef logic [127:0] block_t;

   localparam byte_t CMD_KEY     = "C";
   localparam byte_t CMD_TEXT    = "D";
   localparam byte_t CMD_ENC     = "E";
   localparam byte_t CMD_DKEY    = "K";
   localparam byte_t CMD_DEC     = "X";
   localparam byte_t CMD_RD_ENC  = "@";
   localparam byte_t CMD_RD_DEC  = 8'h60;
   localparam byte_t CMD_RD_KEY  = "a";
   localparam byte_t CMD_RD_TEXT = "b";
   localparam byte_t CMD_PING    = "A";

   localparam byte_t STAT_OK      = "K";
   localparam byte_t STAT_TIMEOUT = "T";
   localparam byte_t STAT_UNKNOWN = "?";

   localparam block_t PING_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT,
      S_RESP
   } state_t;

   function automatic byte_t frame_cmd(input logic [FRAME_W-1:0] f);
      return f[7:0];
   endfunction

   function automatic byte_t frame_copy(input logic [FRAME_W-1:0] f);
      return f[FRAME_W-1 -: 8];
   endfunction

   function automatic block_t frame_payload(input logic [FRAME_W-1:0] f);
      return f[135:8];
   endfunction

   function automatic logic [FRAME_W-1:0] pack_frame(input byte_t hi, input block_t data,
                                                     input byte_t lo);
      return {hi, data, lo};
   endfunction

endpackage

// File: rtl/aes_uart_cmd_sequencer_if.sv
// Frame, AES-core and status signals between uart_top, the sequencer and the AES cores.
interface aes_uart_cmd_sequencer_if;
   import aes_uart_pkg::*;

   logic [FRAME_W-1:0] rx_frame;
   logic               rx_valid;
   logic               tx_ready;
   logic [FRAME_W-1:0] tx_frame;
   logic               tx_send;
   logic [127:0]       aes_key;
   logic [127:0]       aes_text;
   logic               enc_ld;
   logic               dec_kld;
   logic               dec_ld;
   logic               enc_done;
   logic [127:0]       enc_text_out;
   logic               dec_kdone;
   logic               dec_done;
   logic [127:0]       dec_text_out;
   logic               busy;
   logic [7:0]         drop_cnt;

   modport master (
      input  rx_frame, rx_valid, tx_ready, enc_done, enc_text_out,
             dec_kdone, dec_done, dec_text_out,
      output tx_frame, tx_send, aes_key, aes_text, enc_ld, dec_kld, dec_ld,
             busy, drop_cnt
   );

   modport slave (
      output rx_frame, rx_valid, tx_ready, enc_done, enc_text_out,
             dec_kdone, dec_done, dec_text_out,
      input  tx_frame, tx_send, aes_key, aes_text, enc_ld, dec_kld, dec_ld,
             busy, drop_cnt
   );

endinterface

// File: rtl/aes_uart_cmd_sequencer_timer.sv
// Wait timer for AES done: counts while enabled, flags the last allowed cycle.
module aes_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TO_W           = 13
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TO_W-1:0] count_q;

   // Fires in the cycle whose edge would bring the count to TIMEOUT_CYCLES.
   assign expired_o = en_i && (count_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         count_q <= '0;
      end else if (en_i && !expired_o) begin
         count_q <= count_q + TO_W'(1);
      end
   end

endmodule

// File: rtl/aes_uart_cmd_sequencer.sv
// Validates UART command frames, drives the AES cores and builds response frames.
module aes_uart_cmd_sequencer #(
   parameter int unsigned FRAME_BYTES    = 18,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TO_W           = 13
) (
   input logic                       clk,
   input logic                       reset,
   aes_uart_cmd_sequencer_if.master  bus
);
   import aes_uart_pkg::*;

   logic [FRAME_BYTES*8-1:0] rx_frame;
   state_t                   state_q;
   byte_t                    cmd_q;
   block_t                   payload_q, key_q, text_q, enc_res_q, dec_res_q;
   logic [FRAME_W-1:0]       tx_frame_q;
   logic                     enc_ld_q, dec_kld_q, dec_ld_q;
   logic [7:0]               drop_cnt_q;

   byte_t  rx_cmd, exec_status;
   logic   rx_ok, exec_wait, done_seen, timeout;
   block_t exec_data, done_data;

   assign rx_frame = bus.rx_frame;
   assign rx_cmd   = frame_cmd(rx_frame);
   assign rx_ok    = (rx_cmd == frame_copy(rx_frame));

   always_comb begin
      exec_status = STAT_OK;
      exec_data   = '0;
      exec_wait   = 1'b0;
      case (cmd_q)
         CMD_KEY, CMD_TEXT:          exec_data = payload_q;
         CMD_ENC, CMD_DKEY, CMD_DEC: exec_wait = 1'b1;
         CMD_RD_ENC:                 exec_data = enc_res_q;
         CMD_RD_DEC:                 exec_data = dec_res_q;
         CMD_RD_KEY:                 exec_data = key_q;
         CMD_RD_TEXT:                exec_data = text_q;
         CMD_PING:                   exec_data = PING_DATA;
         default:                    exec_status = STAT_UNKNOWN;
      endcase
      done_seen = 1'b0;
      done_data = '0;
      case (cmd_q)
         CMD_ENC:  begin done_seen = bus.enc_done; done_data = bus.enc_text_out; end
         CMD_DKEY: done_seen = bus.dec_kdone;
         CMD_DEC:  begin done_seen = bus.dec_done; done_data = bus.dec_text_out; end
         default:  done_seen = 1'b0;
      endcase
   end

   aes_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TO_W          (TO_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (state_q != S_WAIT),
      .en_i     (state_q == S_WAIT),
      .expired_o(timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         payload_q  <= '0;
         key_q      <= '0;
         text_q     <= '0;
         enc_res_q  <= '0;
         dec_res_q  <= '0;
         tx_frame_q <= '0;
         enc_ld_q   <= 1'b0;
         dec_kld_q  <= 1'b0;
         dec_ld_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         enc_ld_q  <= 1'b0;
         dec_kld_q <= 1'b0;
         dec_ld_q  <= 1'b0;
         if (bus.rx_valid && (state_q != S_IDLE || !rx_ok) && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
         unique case (state_q)
            S_IDLE: begin
               // Strobes are registered here so they are high exactly during EXEC.
               if (bus.rx_valid && rx_ok) begin
                  cmd_q     <= rx_cmd;
                  payload_q <= frame_payload(rx_frame);
                  enc_ld_q  <= (rx_cmd == CMD_ENC);
                  dec_kld_q <= (rx_cmd == CMD_DKEY);
                  dec_ld_q  <= (rx_cmd == CMD_DEC);
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cmd_q == CMD_KEY)  key_q  <= payload_q;
               if (cmd_q == CMD_TEXT) text_q <= payload_q;
               if (exec_wait) begin
                  state_q <= S_WAIT;
               end else begin
                  tx_frame_q <= pack_frame(cmd_q, exec_data, exec_status);
                  state_q    <= S_RESP;
               end
            end
            S_WAIT: begin
               if (done_seen) begin
                  if (cmd_q == CMD_ENC) enc_res_q <= bus.enc_text_out;
                  if (cmd_q == CMD_DEC) dec_res_q <= bus.dec_text_out;
                  tx_frame_q <= pack_frame(cmd_q, done_data, STAT_OK);
                  state_q    <= S_RESP;
               end else if (timeout) begin
                  tx_frame_q <= pack_frame(cmd_q, '0, STAT_TIMEOUT);
                  state_q    <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.tx_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_frame = tx_frame_q;
   assign bus.tx_send  = (state_q == S_RESP) && bus.tx_ready;
   assign bus.aes_key  = key_q;
   assign bus.aes_text = text_q;
   assign bus.enc_ld   = enc_ld_q;
   assign bus.dec_kld  = dec_kld_q;
   assign bus.dec_ld   = dec_ld_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.drop_cnt = drop_cnt_q;

endmodule
